// File: rtl/fft_r22sdf_ctrl.sv
// Control sequencer for a radix-2^2 SDF FFT pipeline: butterfly selects, twiddle addresses, output framing.
// Define FFT_CTRL_BITREV_EN to report idx_o as the natural-order bin number instead of raw output order.
module fft_r22sdf_ctrl #(
    parameter int unsigned LOG2N  = 6,
    parameter int unsigned TW_LAT = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_n,
    input  logic                               valid_i,
    output logic                               zero_o,
    output logic [LOG2N/2-1:0]                 bfi_sel_o,
    output logic [LOG2N/2-1:0]                 bfii_sel_o,
    output logic [LOG2N/2-1:0]                 bfii_tsel_o,
    output logic [(LOG2N/2-1)*LOG2N-1:0]       tw_addr_o,
    output logic                               valid_o,
    output logic                               sync_o,
    output logic [LOG2N-1:0]                   idx_o,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int unsigned N    = 1 << LOG2N;
    localparam int unsigned NSTG = LOG2N / 2;

    function automatic int unsigned d_bfi(input int unsigned s);
        int unsigned d;
        d = 0;
        for (int unsigned i = 0; i < s; i++)
            d = d + (N >> (2*i + 1)) + (N >> (2*i + 2)) + TW_LAT;
        return d;
    endfunction

    function automatic int unsigned d_bfii(input int unsigned s);
        return d_bfi(s) + (N >> (2*s + 1));
    endfunction

    function automatic int unsigned d_mul(input int unsigned s);
        return d_bfii(s) + (N >> (2*s + 2));
    endfunction

`ifdef FFT_CTRL_BITREV_EN
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int unsigned i = 0; i < LOG2N; i++)
            r[i] = v[LOG2N-1-i];
        return r;
    endfunction
`endif

    localparam int unsigned      D_TOT      = d_bfii(NSTG-1) + 1;
    localparam int unsigned      FW         = $clog2(D_TOT + 1);
    localparam logic [FW-1:0]    FILL_MAX   = FW'(D_TOT);
    localparam logic [FW-1:0]    DRAIN_LAST = FW'(D_TOT - 1);
    localparam logic [LOG2N-1:0] OC_OFF     = LOG2N'(D_TOT % N);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           state_q, state_nx;
    logic [LOG2N-1:0] ctr_q, ctr_nx;
    logic [FW-1:0]    fill_q, fill_nx;
    logic [FW-1:0]    drain_q, drain_nx;
    logic             err_q, err_nx;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
            fill_q  <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            ctr_q   <= ctr_nx;
            fill_q  <= fill_nx;
            drain_q <= drain_nx;
            err_q   <= err_nx;
        end
    end

    // fill saturates at D_TOT: it only has to tell which units have seen their first sample
    always_comb begin
        state_nx = state_q;
        ctr_nx   = ctr_q;
        fill_nx  = fill_q;
        drain_nx = drain_q;
        err_nx   = err_q;
        zero_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    state_nx = S_RUN;
                    ctr_nx   = LOG2N'(1);
                    fill_nx  = FW'(1);
                end
            end
            S_RUN: begin
                ctr_nx = ctr_q + 1'b1;
                if (fill_q != FILL_MAX) fill_nx = fill_q + 1'b1;
                if (!valid_i) begin
                    if (ctr_q == '0) begin
                        state_nx = S_DRAIN;
                        drain_nx = '0;
                    end else begin
                        err_nx = 1'b1;
                        zero_o = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                ctr_nx = ctr_q + 1'b1;
                if (fill_q != FILL_MAX) fill_nx = fill_q + 1'b1;
                if (valid_i) err_nx = 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    state_nx = S_IDLE;
                    ctr_nx   = '0;
                    fill_nx  = '0;
                    drain_nx = '0;
                end else begin
                    drain_nx = drain_q + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Controls are computed from next-state values so the registered outputs line up with ctr_q
    logic                         busy_nx, valid_nx, sync_nx;
    logic [LOG2N-1:0]             oc_nx, idx_nx;
    logic [NSTG-1:0]              bfi_nx, sel_nx, tsel_nx;
    logic [(NSTG-1)*LOG2N-1:0]    tw_nx;

    assign busy_nx  = (state_nx != S_IDLE);
    assign valid_nx = busy_nx && (fill_nx == FILL_MAX) &&
                      !((state_nx == S_DRAIN) && (drain_nx == DRAIN_LAST));
    assign oc_nx    = ctr_nx - OC_OFF;
    assign sync_nx  = valid_nx && (oc_nx == '0);
`ifdef FFT_CTRL_BITREV_EN
    assign idx_nx   = valid_nx ? bitrev(oc_nx) : '0;
`else
    assign idx_nx   = valid_nx ? oc_nx : '0;
`endif

    for (genvar s = 0; s < NSTG; s++) begin : g_stage
        localparam int unsigned   M   = LOG2N - 2*s;
        localparam logic [M-1:0]  DB  = M'(d_bfi(s));
        localparam logic [M-1:0]  DII = M'(d_bfii(s));
        localparam logic [FW-1:0] FB  = FW'(d_bfi(s));
        localparam logic [FW-1:0] FI  = FW'(d_bfii(s));
        logic       act_bi, act_ii;
        logic [1:0] top_ii;

        if (d_bfi(s) == 0) begin : g_bi_first
            assign act_bi = busy_nx;
        end else begin : g_bi_later
            assign act_bi = busy_nx && (fill_nx >= FB);
        end
        assign act_ii = busy_nx && (fill_nx >= FI);

        assign bfi_nx[s]  = act_bi && 1'(M'(ctr_nx[M-1:0] - DB) >> (M-1));
        assign top_ii     = 2'(M'(ctr_nx[M-1:0] - DII) >> (M-2));
        assign sel_nx[s]  = act_ii && top_ii[0];
        assign tsel_nx[s] = act_ii && !top_ii[1];

        if (s < NSTG-1) begin : g_tw
            localparam int unsigned   MN = M - 2;
            localparam logic [M-1:0]  DM = M'(d_mul(s));
            localparam logic [FW-1:0] FM = FW'(d_mul(s));
            logic [1:0]       q;
            logic [MN-1:0]    n;
            logic [LOG2N-1:0] prod;

            // quadrant -> twiddle multiple {0,2,1,3} is a bit swap of q
            assign q    = 2'(M'(ctr_nx[M-1:0] - DM) >> MN);
            assign n    = MN'(M'(ctr_nx[M-1:0] - DM));
            assign prod = LOG2N'({q[0], q[1]}) * LOG2N'(n);
            assign tw_nx[s*LOG2N +: LOG2N] =
                (busy_nx && (fill_nx >= FM)) ? (prod << (2*s)) : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            bfi_sel_o   <= '0;
            bfii_sel_o  <= '0;
            bfii_tsel_o <= '0;
            tw_addr_o   <= '0;
            valid_o     <= 1'b0;
            sync_o      <= 1'b0;
            idx_o       <= '0;
            busy_o      <= 1'b0;
        end else begin
            bfi_sel_o   <= bfi_nx;
            bfii_sel_o  <= sel_nx;
            bfii_tsel_o <= tsel_nx;
            tw_addr_o   <= tw_nx;
            valid_o     <= valid_nx;
            sync_o      <= sync_nx;
            idx_o       <= idx_nx;
            busy_o      <= busy_nx;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_fft_r22sdf_ctrl.sv
// Scoreboard bench for fft_r22sdf_ctrl (LOG2N=4, TW_LAT=2): frame sequencing, controls, errors, reset.
module tb_fft_r22sdf_ctrl;

    localparam int LOG2N  = 4;
    localparam int TW_LAT = 2;
    localparam int N      = 1 << LOG2N;
    localparam int NSTG   = LOG2N / 2;
    localparam int TWW    = (NSTG - 1) * LOG2N;
    localparam longint INF = longint'(1) << 60;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_i = 1'b0;
    logic             zero_o, valid_o, sync_o, busy_o, err_o;
    logic [NSTG-1:0]  bfi_sel_o, bfii_sel_o, bfii_tsel_o;
    logic [TWW-1:0]   tw_addr_o;
    logic [LOG2N-1:0] idx_o;

    fft_r22sdf_ctrl #(.LOG2N(LOG2N), .TW_LAT(TW_LAT)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .zero_o(zero_o),
        .bfi_sel_o(bfi_sel_o), .bfii_sel_o(bfii_sel_o), .bfii_tsel_o(bfii_tsel_o),
        .tw_addr_o(tw_addr_o), .valid_o(valid_o), .sync_o(sync_o), .idx_o(idx_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { longint cyc; int idx; bit sync; } exp_t;
    exp_t sbq[$];

    int     tests = 0, fails = 0;
    longint cyc = 0;
    bit     mon_en = 1'b0;
    bit     sess_active = 1'b0;
    longint sess_start = 0;
    int     sess_frames = 0;
    longint err_from = INF;
    longint drop_cyc = -1;
    int     d_bfi[NSTG], d_bfii[NSTG], d_mul[NSTG];
    int     d_tot;
    int     KTAB[4]     = '{0, 2, 1, 3};
    int     TW0_TAB[16] = '{0,0,0,0, 0,2,4,6, 0,1,2,3, 0,3,6,9};

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++)
            if (((v >> i) & 1) == 1) r = r | (1 << (LOG2N - 1 - i));
        return r;
    endfunction

    function automatic int idx_of(input int o);
`ifdef FFT_CTRL_BITREV_EN
        return bitrev(o);
`else
        return o;
`endif
    endfunction

    function automatic int lcount(input longint t, input int d, input int m);
        return int'(((t - d) % N) % (1 << m));
    endfunction

    // Monitor: per-cycle control model plus scoreboard pops on valid_o
    longint           t;
    bit               bz;
    int               m, lc, qv, nv, addr;
    logic [NSTG-1:0]  e_bfi, e_sel, e_tsel;
    logic [TWW-1:0]   e_tw;
    exp_t             e;

    always @(negedge clk_i) begin
        if (mon_en) begin
            t  = cyc - sess_start;
            bz = sess_active && t >= 1 && t <= longint'(sess_frames * N + d_tot);
            check("busy", busy_o, bz);
            check("err", err_o, cyc >= err_from);
            check("zero", zero_o, sess_active && cyc == drop_cyc);
            e_bfi = '0; e_sel = '0; e_tsel = '0; e_tw = '0;
            for (int s = 0; s < NSTG; s++) begin
                m = LOG2N - 2*s;
                if (bz && t >= d_bfi[s]) begin
                    lc = lcount(t, d_bfi[s], m);
                    e_bfi[s] = (lc >= (1 << (m-1)));
                end
                if (bz && t >= d_bfii[s]) begin
                    lc = lcount(t, d_bfii[s], m);
                    e_sel[s]  = ((lc / (1 << (m-2))) % 2) == 1;
                    e_tsel[s] = (lc < (1 << (m-1)));
                end
                if (s < NSTG-1 && bz && t >= d_mul[s]) begin
                    lc   = lcount(t, d_mul[s], m);
                    qv   = lc / (1 << (m-2));
                    nv   = lc % (1 << (m-2));
                    addr = (((KTAB[qv] * nv) % N) * (1 << (2*s))) % N;
                    e_tw[s*LOG2N +: LOG2N] = LOG2N'(addr);
                    if (s == 0) check("tw0_table", tw_addr_o[LOG2N-1:0], TW0_TAB[lc]);
                end
            end
            check("bfi_sel", bfi_sel_o, e_bfi);
            check("bfii_sel", bfii_sel_o, e_sel);
            check("bfii_tsel", bfii_tsel_o, e_tsel);
            check("tw_addr", tw_addr_o, e_tw);
            if (valid_o) begin
                if (sbq.size() == 0) begin
                    check("valid_unexpected", valid_o, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    check("valid_cycle", cyc, e.cyc);
                    check("idx", idx_o, e.idx);
                    check("sync", sync_o, e.sync);
                end
            end else begin
                check("idle_idx", idx_o, 0);
                check("idle_sync", sync_o, 1'b0);
                if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    check("valid_missing", valid_o, 1'b1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_session(input int frames);
        exp_t ent;
        sess_start  = cyc;
        sess_frames = frames;
        sess_active = 1'b1;
        drop_cyc    = -1;
        for (int g = 0; g < frames * N; g++) begin
            ent.cyc  = sess_start + g + d_tot;
            ent.idx  = idx_of(g % N);
            ent.sync = (g % N) == 0;
            sbq.push_back(ent);
        end
    endtask

    task automatic run_session(input int frames, input int drop_at, input int poke);
        start_session(frames);
        for (int g = 0; g < frames * N; g++) begin
            valid_i = (g != drop_at);
            if (g == drop_at) begin
                drop_cyc = cyc;
                if (err_from > cyc + 1) err_from = cyc + 1;
            end
            step();
        end
        for (int d = 0; d <= d_tot; d++) begin
            valid_i = (d == poke);
            if (d == poke && err_from > cyc + 1) err_from = cyc + 1;
            step();
        end
        valid_i = 1'b0;
        repeat ($urandom_range(0, 3)) step();
    endtask

    task automatic reset_mid_run();
        int k;
        k = $urandom_range(d_tot + 2, N + 10);
        start_session(2);
        for (int g = 0; g < k; g++) begin
            valid_i = 1'b1;
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n       = 1'b1;
        valid_i     = 1'b0;
        sbq.delete();
        sess_active = 1'b0;
        err_from    = INF;
        drop_cyc    = -1;
        repeat (2) step();
    endtask

    initial begin
        int acc, f, drop, poke;
        acc = 0;
        for (int s = 0; s < NSTG; s++) begin
            d_bfi[s]  = acc;  acc += N >> (2*s + 1);
            d_bfii[s] = acc;  acc += N >> (2*s + 2);
            d_mul[s]  = acc;  acc += TW_LAT;
        end
        d_tot = d_bfii[NSTG-1] + 1;

        step();
        mon_en = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        run_session(1, -1, -1);
        run_session(3, -1, -1);
        run_session(2, 5, -1);
        for (int r = 0; r < 4; r++) begin
            f    = $urandom_range(1, 3);
            drop = ($urandom_range(0, 1) == 1) ?
                   $urandom_range(0, f - 1) * N + $urandom_range(1, N - 1) : -1;
            poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, d_tot) : -1;
            run_session(f, drop, poke);
        end
        reset_mid_run();
        run_session(1, -1, -1);
        run_session(2, -1, $urandom_range(1, d_tot));
        reset_mid_run();
        run_session(1, -1, -1);
        repeat (3) step();
        check("scoreboard_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
